uart_work_rx: RTL and testbench
===============================

UART_WORK_RX -- requirements
Module: uart_work_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; bit period DIV = CLK_HZ/BAUD (integer division; 434 at defaults).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5000000, idle clocks before a partial packet is discarded.
REQ-004 osc_clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 RxD  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 midstate  output  256  SHA-256 midstate of the last complete work packet.
REQ-008 data  output  96  trailing block-header words of the last complete work packet.
REQ-009 new_work  output  1  one-cycle pulse when midstate/data update.
REQ-010 rx_busy  output  1  high while a packet is partially assembled.
REQ-011 frame_err  output  1  one-cycle pulse on a stop-bit error.

Function
REQ-012 RxD SHALL pass through a two-flop synchronizer before any use; 2-cycle input latency.
REQ-013 Byte FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE: on synchronized RxD=0 go to START and load bit counter with DIV/2.
REQ-015 START: at counter expiry resample; if 0 go to DATA with counter DIV, else (glitch) return to IDLE without error.
REQ-016 DATA: sample every DIV clocks, shifting into bit 7 (LSB first), 8 samples, then STOP.
REQ-017 STOP: sample after DIV; 1 -> byte valid for one cycle and go to IDLE; 0 -> frame_err pulse, byte discarded, whole partial packet discarded, and wait in STOP until RxD=1 before IDLE.
REQ-018 Packet = 44 bytes; each valid byte shifts into a 352-bit register from the LSB end, so the first byte ends in bits [351:344].
REQ-019 On the 44th valid byte, SHALL load midstate = reg[351:96], data = reg[95:0] and pulse new_work in the next cycle; byte count returns to 0.
REQ-020 midstate/data SHALL hold their value between packets; never change except per REQ-019 or reset.
REQ-021 rx_busy = (byte count != 0).
REQ-022 Byte count SHALL be 6 bits, saturating logic not required: it never exceeds 43 before wrap to 0.
REQ-023 A start bit arriving in the same cycle as new_work SHALL be accepted normally (no byte lost).

Reset
REQ-024 rst_n low SHALL asynchronously set FSM to IDLE, counters, shift register, byte count, midstate, data to 0; new_work, frame_err, rx_busy to 0; synchronizer flops to 1.
REQ-025 Reset asserted mid-byte or mid-packet SHALL discard all partial state; no new_work produced.

Configuration
REQ-026 Macro UART_WORK_RX_TIMEOUT_EN defined: an idle counter (reset on each valid byte) SHALL clear byte count when rx_busy and count reaches TIMEOUT_CYC; no output pulse.
REQ-027 Macro undefined: no timeout logic; partial packets persist indefinitely.

Structure
REQ-028 Shared package SHALL hold PKT_BYTES=44, MIDSTATE_W=256, DATA_W=96 and the FSM state enum.
REQ-029 Byte receiver (REQ-012..017) SHALL be sub-module uart_rx_byte; packet assembly in uart_work_rx.

Verification
REQ-030 44 bytes 0x00..0x2B at 115200 baud, defaults -> one new_work pulse; midstate[255:248]=0x00, data[7:0]=0x2B.
REQ-031 Byte with stop bit 0 after 10 good bytes -> frame_err pulse, rx_busy falls, next 44 good bytes give correct packet.
REQ-032 RxD low pulse of 100 clocks -> no byte, no frame_err, FSM back to IDLE.
REQ-033 rst_n asserted after byte 20 -> all outputs 0 immediately; following full packet decodes correctly.
REQ-034 With UART_WORK_RX_TIMEOUT_EN, TIMEOUT_CYC=1000: 5 bytes then 2000 idle clocks -> rx_busy 0; next 44 bytes -> correct packet.
REQ-035 Two packets back-to-back with zero inter-byte gap -> two new_work pulses, second values replace first.

Source files
------------

// File: rtl/uart_work_rx_pkg.sv
// Shared definitions for the UART work-packet receiver: packet geometry,
// the byte-receiver state encoding and the bit-period helper.
package uart_work_rx_pkg;

  localparam int PKT_BYTES  = 44;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int PKT_W      = MIDSTATE_W + DATA_W;
  localparam int BYTE_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Clocks per serial bit (integer division).
  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver. The line is synchronized through two flops, the
// start bit is verified at its centre, and data/stop bits are sampled once
// per bit period from that point. A low stop bit raises a one-cycle
// frame_err and parks the receiver until the line returns high.
module uart_rx_byte
  import uart_work_rx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       osc_clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV   = bit_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV + 1);

  // The counter expires when it reads one, so a load of N means N clocks.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             err_wait_q, err_wait_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             expired;

  // Two-flop synchronizer, reset to the idle (mark) level of the line.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
    end
  end

  assign expired = (cnt_q == CNT_ONE);

  // State and datapath registers for the byte FSM.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      err_wait_q <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      err_wait_q <= err_wait_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state, bit timing and sampling decisions.
  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    err_wait_d = err_wait_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end

      START: begin
        if (expired) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
            bit_d   = '0;
          end else begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DATA: begin
        if (expired) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      STOP: begin
        if (err_wait_q) begin
          // Break or framing fault: hold off until the line idles high.
          if (rx_s) begin
            state_d    = IDLE;
            err_wait_d = 1'b0;
          end
        end else if (expired) begin
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d     = 1'b1;
            err_wait_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_byte    = shreg_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_work_rx.sv
// Mining work-packet receiver. Assembles 44 UART bytes into a 352-bit
// packet (first byte most significant) and publishes it as a 256-bit
// midstate plus 96 bits of trailing header data, with a one-cycle
// new_work strobe. A framing error drops the partial packet.
// Optional build macro: UART_WORK_RX_TIMEOUT_EN adds an idle timeout that
// drops a partial packet after TIMEOUT_CYC clocks without a valid byte.
module uart_work_rx
  import uart_work_rx_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                  osc_clk,
  input  logic                  rst_n,
  input  logic                  RxD,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [DATA_W-1:0]     data,
  output logic                  new_work,
  output logic                  rx_busy,
  output logic                  frame_err
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(PKT_BYTES - 1);

  logic [7:0]            rx_byte;
  logic                  byte_valid;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [PKT_W-1:0]      pkt_sr;
  logic                  load_pend;
  logic                  timeout_hit;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_byte (
    .osc_clk    (osc_clk),
    .rst_n      (rst_n),
    .rxd        (RxD),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign rx_busy = (byte_cnt != '0);

`ifdef UART_WORK_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idle_cnt;

  // Idle clock counter: runs only while a packet is open, restarts per byte.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (byte_valid || !rx_busy || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign timeout_hit = rx_busy && (idle_cnt == IDLE_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  // Packet assembly: shift bytes in from the LSB end and count them.
  // NOTE: the wide packet register is reset even though it is fully
  // overwritten before use, so no stale reset-time contents are ever visible.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      pkt_sr    <= '0;
      load_pend <= 1'b0;
    end else begin
      load_pend <= 1'b0;
      if (frame_err) begin
        byte_cnt <= '0;
      end else if (byte_valid) begin
        pkt_sr <= {pkt_sr[PKT_W-9:0], rx_byte};
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt  <= '0;
          load_pend <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
        end
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end
    end
  end

  // Publish a completed packet; outputs hold until the next one.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      midstate <= '0;
      data     <= '0;
      new_work <= 1'b0;
    end else begin
      new_work <= load_pend;
      if (load_pend) begin
        midstate <= pkt_sr[PKT_W-1:DATA_W];
        data     <= pkt_sr[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_work_rx.sv
// Self-checking bench for uart_work_rx. Runs with a 16-clock bit period so
// whole packets fit in a short simulation. Define UART_WORK_RX_TIMEOUT_EN
// for both bench and RTL to exercise the idle-timeout build.
module tb_uart_work_rx;
  import uart_work_rx_pkg::*;

  localparam int CLK_HZ  = 1600000;
  localparam int BAUD    = 100000;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int TIMEOUT = 1000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  rxd;
  logic [MIDSTATE_W-1:0] midstate;
  logic [DATA_W-1:0]     data;
  logic                  new_work;
  logic                  rx_busy;
  logic                  frame_err;

  int checks   = 0;
  int failures = 0;
  int nw_cnt   = 0;
  int fe_cnt   = 0;
  logic [MIDSTATE_W-1:0] snap_mid [8];
  logic [DATA_W-1:0]     snap_dat [8];

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_busy;
    int         exp_fe;
  } vec_t;

  vec_t vecs [11];

  uart_work_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .osc_clk   (clk),
    .rst_n     (rst_n),
    .RxD       (rxd),
    .midstate  (midstate),
    .data      (data),
    .new_work  (new_work),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Count output strobes (in high cycles) and snapshot each published packet.
  always @(negedge clk) begin
    if (new_work) begin
      if (nw_cnt < 8) begin
        snap_mid[nw_cnt] = midstate;
        snap_dat[nw_cnt] = data;
      end
      nw_cnt++;
    end
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string name, input logic [PKT_W-1:0] act,
                       input logic [PKT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(DIV);
    end
    rxd = stop;
    idle(DIV);
    rxd = 1'b1;
  endtask

  task automatic send_bytes(input logic [7:0] base, input logic [7:0] step,
                            input int first, input int last);
    logic [7:0] b;
    for (int i = first; i <= last; i++) begin
      b = base + step * 8'(i);
      send_byte(b, 1'b1);
    end
  endtask

  // Expected packet: byte i lands in bits [351-8i -: 8].
  function automatic logic [PKT_W-1:0] exp_pkt(input logic [7:0] base,
                                               input logic [7:0] step);
    logic [PKT_W-1:0] p;
    p = '0;
    for (int i = 0; i < PKT_BYTES; i++) p[PKT_W-1-8*i -: 8] = base + step * 8'(i);
    return p;
  endfunction

  task automatic check_packet(input string name, input int idx,
                              input logic [PKT_W-1:0] exp);
    check({name, " midstate"}, PKT_W'(snap_mid[idx]), PKT_W'(exp[PKT_W-1:DATA_W]));
    check({name, " data"}, PKT_W'(snap_dat[idx]), PKT_W'(exp[DATA_W-1:0]));
  endtask

  initial begin
    int nw_base;
    int fe_base;
    logic [PKT_W-1:0] pa;
    logic [PKT_W-1:0] pb;
    logic [PKT_W-1:0] pc;
    logic [PKT_W-1:0] pd;

    for (int i = 0; i < 10; i++) begin
      vecs[i].b        = 8'h5A ^ 8'(i * 17);
      vecs[i].stop     = 1'b1;
      vecs[i].exp_busy = 1'b1;
      vecs[i].exp_fe   = 0;
    end
    vecs[10].b        = 8'hC3;
    vecs[10].stop     = 1'b0;
    vecs[10].exp_busy = 1'b0;
    vecs[10].exp_fe   = 1;

    pa = exp_pkt(8'h00, 8'h01);
    pb = exp_pkt(8'h3C, 8'h05);
    pc = exp_pkt(8'h10, 8'h07);
    pd = exp_pkt(8'hF0, 8'hFD);

    // Reset state.
    rst_n = 1'b0;
    rxd   = 1'b1;
    idle(3);
    check("reset midstate", PKT_W'(midstate), '0);
    check("reset data", PKT_W'(data), '0);
    check("reset new_work", PKT_W'(new_work), '0);
    check("reset rx_busy", PKT_W'(rx_busy), '0);
    check("reset frame_err", PKT_W'(frame_err), '0);
    rst_n = 1'b1;
    idle(DIV);
    check("idle rx_busy", PKT_W'(rx_busy), '0);

    // Ten good bytes then a byte with a low stop bit.
    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].b, vecs[i].stop);
      idle(DIV);
      check($sformatf("vec%0d rx_busy", i), PKT_W'(rx_busy), PKT_W'(vecs[i].exp_busy));
      check($sformatf("vec%0d frame_err count", i), PKT_W'(fe_cnt), PKT_W'(vecs[i].exp_fe));
    end
    check("no new_work after frame error", PKT_W'(nw_cnt), '0);

    // Full packet 0x00..0x2B, back-to-back bytes.
    send_bytes(8'h00, 8'h01, 0, PKT_BYTES - 1);
    idle(DIV);
    check("pkt A new_work count", PKT_W'(nw_cnt), PKT_W'(1));
    check("pkt A midstate[255:248]", PKT_W'(midstate[255:248]), PKT_W'(8'h00));
    check("pkt A data[7:0]", PKT_W'(data[7:0]), PKT_W'(8'h2B));
    check_packet("pkt A", 0, pa);
    check("pkt A rx_busy after", PKT_W'(rx_busy), '0);

    // Short low glitch: no byte, no error, FSM back to idle.
    fe_base = fe_cnt;
    rxd = 1'b0;
    idle(DIV / 4);
    rxd = 1'b1;
    idle(3 * DIV);
    check("glitch frame_err count", PKT_W'(fe_cnt), PKT_W'(fe_base));
    check("glitch rx_busy", PKT_W'(rx_busy), '0);
    check("glitch new_work count", PKT_W'(nw_cnt), PKT_W'(1));
    check("glitch fsm idle", PKT_W'(dut.u_byte.state_q), PKT_W'(IDLE));

    // Reset after 20 bytes of a packet: outputs clear at once.
    send_bytes(8'h80, 8'h01, 0, 19);
    idle(4);
    check("partial rx_busy", PKT_W'(rx_busy), PKT_W'(1));
    rst_n = 1'b0;
    #1;
    check("async reset midstate", PKT_W'(midstate), '0);
    check("async reset data", PKT_W'(data), '0);
    check("async reset rx_busy", PKT_W'(rx_busy), '0);
    idle(2);
    rst_n = 1'b1;
    idle(DIV);
    send_bytes(8'h3C, 8'h05, 0, PKT_BYTES - 1);
    idle(DIV);
    check("pkt B new_work count", PKT_W'(nw_cnt), PKT_W'(2));
    check_packet("pkt B", 1, pb);

    // Two packets with zero inter-byte gap.
    send_bytes(8'h10, 8'h07, 0, PKT_BYTES - 1);
    send_bytes(8'hF0, 8'hFD, 0, PKT_BYTES - 1);
    idle(DIV);
    check("b2b new_work count", PKT_W'(nw_cnt), PKT_W'(4));
    check_packet("pkt C", 2, pc);
    check_packet("pkt D", 3, pd);
    check("pkt D held midstate", PKT_W'(midstate), PKT_W'(pd[PKT_W-1:DATA_W]));
    check("pkt D held data", PKT_W'(data), PKT_W'(pd[DATA_W-1:0]));

    // Five bytes then a long idle gap.
    nw_base = nw_cnt;
    send_bytes(8'h00, 8'h01, 0, 4);
    idle(4);
    check("pre-gap rx_busy", PKT_W'(rx_busy), PKT_W'(1));
    idle(2000);
`ifdef UART_WORK_RX_TIMEOUT_EN
    check("timeout rx_busy", PKT_W'(rx_busy), '0);
    check("timeout new_work count", PKT_W'(nw_cnt), PKT_W'(nw_base));
    send_bytes(8'h00, 8'h01, 0, PKT_BYTES - 1);
`else
    check("no-timeout rx_busy", PKT_W'(rx_busy), PKT_W'(1));
    check("no-timeout new_work count", PKT_W'(nw_cnt), PKT_W'(nw_base));
    send_bytes(8'h00, 8'h01, 5, PKT_BYTES - 1);
`endif
    idle(DIV);
    check("gap pkt new_work count", PKT_W'(nw_cnt), PKT_W'(nw_base + 1));
    check_packet("gap pkt", nw_base, pa);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
